// File: rtl/rom_fetch_pkg.sv
// Shared types and widths for the F8 byte-stream instruction fetch front-end.
package rom_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;

endpackage

// File: rtl/fetch_byte_fifo.sv
// Circular prefetch byte buffer: two bytes in per push, one byte out per pop, synchronous flush.
module fetch_byte_fifo
    import rom_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_lo,
    input  logic [BYTE_W-1:0] push_hi,
    input  logic              pop,
    output logic [CW-1:0]     count,
    output logic [BYTE_W-1:0] head_data
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]          <= push_lo;
            mem[wr_ptr + PW'(1)] <= push_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(2);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(2);
                2'b01:   count <= count - CW'(1);
                2'b11:   count <= count + CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/rom_fetch.sv
// Instruction fetch front-end over the dual even/odd ROM port, with redirect flush.
// Optional stall counter port enabled by defining ROM_FETCH_PERF_EN.
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h4000,
    parameter int                BUF_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-2:0] read_addr_even,
    output logic [ADDR_W-2:0] read_addr_odd,
    input  logic [BYTE_W-1:0] read_data_even,
    input  logic [BYTE_W-1:0] read_data_odd,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready
`ifdef ROM_FETCH_PERF_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int CW = $clog2(BUF_BYTES) + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_ptr;
    logic [ADDR_W-1:0] ptr_plus1;
    logic [ADDR_W-1:0] head_addr;
    logic              pending;
    logic              pend_lo_odd;
    logic              space_ok;
    logic              issue;
    logic              pop;
    logic              push;
    logic [CW-1:0]     count;
    logic [BYTE_W-1:0] head_data;
    logic [BYTE_W-1:0] push_lo;
    logic [BYTE_W-1:0] push_hi;

    // Reserve room for the in-flight pair plus the new pair; a same-cycle pop is not credited.
    assign space_ok = (int'(count) + (pending ? 2 : 0) + 2) <= BUF_BYTES;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            RUN: begin
                if (!fetch_en) state_next = IDLE;
                issue = fetch_en && !redirect_valid && space_ok;
            end
            IDLE: begin
                if (fetch_en) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_ptr   <= RESET_PC;
            head_addr   <= RESET_PC;
            pending     <= 1'b0;
            pend_lo_odd <= 1'b0;
        end else if (redirect_valid) begin
            fetch_ptr <= redirect_addr;
            head_addr <= redirect_addr;
            pending   <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                fetch_ptr   <= fetch_ptr + 16'd2;
                pend_lo_odd <= fetch_ptr[0];
            end
            if (pop) head_addr <= head_addr + 16'd1;
        end
    end

    // (p+1)>>1 equals p>>1 for even p, so one expression covers both alignments and the wrap.
    assign ptr_plus1      = fetch_ptr + 16'd1;
    assign read_addr_odd  = fetch_ptr[ADDR_W-1:1];
    assign read_addr_even = ptr_plus1[ADDR_W-1:1];

    assign push_lo = pend_lo_odd ? read_data_odd  : read_data_even;
    assign push_hi = pend_lo_odd ? read_data_even : read_data_odd;
    assign push    = pending && !redirect_valid;
    assign pop     = out_valid && out_ready;

    fetch_byte_fifo #(
        .DEPTH(BUF_BYTES)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_lo  (push_lo),
        .push_hi  (push_hi),
        .pop      (pop),
        .count    (count),
        .head_data(head_data)
    );

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? head_data : '0;
    assign out_addr  = head_addr;

`ifdef ROM_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            stall_count <= '0;
        end else if (state == RUN && !out_valid && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rom_fetch.sv
// Directed self-checking bench for rom_fetch against a registered dual-port ROM model.
module tb_rom_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0000;
    logic [14:0] read_addr_even;
    logic [14:0] read_addr_odd;
    logic [7:0]  read_data_even;
    logic [7:0]  read_data_odd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_addr;
    logic        out_ready = 1'b1;
`ifdef ROM_FETCH_PERF_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int failures = 0;
    int gaps;

    always #5 clk = ~clk;

    rom_fetch #(
        .RESET_PC (16'h4000),
        .BUF_BYTES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .read_addr_even(read_addr_even),
        .read_addr_odd (read_addr_odd),
        .read_data_even(read_data_even),
        .read_data_odd (read_data_odd),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .out_ready     (out_ready)
`ifdef ROM_FETCH_PERF_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    // ROM contents: 0x4000.. holds 0x10,0x11,... and the high byte perturbs other pages.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] + a[15:8] - 8'h30;
    endfunction

    always_ff @(posedge clk) begin
        read_data_even <= rom_byte({read_addr_even, 1'b0});
        read_data_odd  <= rom_byte({read_addr_odd, 1'b1});
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        redirect_valid = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic expect_stream(input logic [15:0] start, input int n, output int gap_cycles);
        logic [15:0] a;
        int waited;
        a = start;
        gap_cycles = 0;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!out_valid && waited < 10) begin
                tick;
                waited++;
            end
            if (i > 0) gap_cycles += waited;
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stream_timeout at addr %h: out_valid=%b, expected 1", a, out_valid);
                return;
            end
            checks++;
            if (out_addr !== a || out_data !== rom_byte(a)) begin
                failures++;
                $display("[TB] FAIL stream_byte: got addr=%h data=%h, expected addr=%h data=%h",
                         out_addr, out_data, a, rom_byte(a));
            end
            a = a + 16'd1;
            tick;
        end
    endtask

    task automatic test_reset;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        do_reset;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_addr !== 16'h4000) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h addr=%h, expected 0/00/4000",
                     out_valid, out_data, out_addr);
        end
        checks++;
        if (read_addr_even !== 15'h2000 || read_addr_odd !== 15'h2000) begin
            failures++;
            $display("[TB] FAIL reset_ports: got even=%h odd=%h, expected 2000/2000", read_addr_even, read_addr_odd);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || read_addr_even !== 15'h2001) begin
            failures++;
            $display("[TB] FAIL cycle1: got valid=%b even=%h, expected 0/2001", out_valid, read_addr_even);
        end
        tick;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cycle2_valid: got %b, expected 1", out_valid);
        end
        expect_stream(16'h4000, 12, gaps);
        checks++;
        if (gaps !== 0) begin
            failures++;
            $display("[TB] FAIL throughput_reset: got %0d bubble cycles, expected 0", gaps);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        fetch_en = 1'b1;
        do_reset;
        tick;
        tick;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 || out_addr !== 16'h4000) begin
                failures++;
                $display("[TB] FAIL hold_head cycle %0d: got valid=%b data=%h addr=%h, expected 1/10/4000",
                         i, out_valid, out_data, out_addr);
            end
            tick;
        end
        checks++;
        if (read_addr_even !== 15'h2002 || read_addr_odd !== 15'h2002) begin
            failures++;
            $display("[TB] FAIL stalled_ptr: got even=%h odd=%h, expected 2002/2002", read_addr_even, read_addr_odd);
        end
        out_ready = 1'b1;
        expect_stream(16'h4000, 10, gaps);
        checks++;
        if (gaps !== 0) begin
            failures++;
            $display("[TB] FAIL throughput_release: got %0d bubble cycles, expected 0", gaps);
        end
    endtask

    task automatic test_redirect_odd;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 16'h4003;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if (read_addr_odd !== 15'h2001 || read_addr_even !== 15'h2002) begin
            failures++;
            $display("[TB] FAIL redirect_ports: got odd=%h even=%h, expected 2001/2002", read_addr_odd, read_addr_even);
        end
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 16'h4003) begin
            failures++;
            $display("[TB] FAIL redirect_flush: got valid=%b addr=%h, expected 0/4003", out_valid, out_addr);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL redirect_cycle1: got valid=%b, expected 0", out_valid);
        end
        tick;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL redirect_latency: got valid=%b, expected 1", out_valid);
        end
        expect_stream(16'h4003, 6, gaps);
        checks++;
        if (gaps !== 0) begin
            failures++;
            $display("[TB] FAIL throughput_redirect: got %0d bubble cycles, expected 0", gaps);
        end
    endtask

    // Two redirect phases one cycle apart so one of them lands while a response is in flight.
    task automatic test_redirect_pending;
        logic [15:0] base;
        logic [15:0] target;
        for (int k = 0; k < 2; k++) begin
            base = 16'h5000 + 16'(k * 16'h0100);
            target = 16'h6001 + 16'(k);
            redirect_valid = 1'b1;
            redirect_addr = base;
            tick;
            redirect_valid = 1'b0;
            expect_stream(base, 4 + k, gaps);
            redirect_valid = 1'b1;
            redirect_addr = target;
            tick;
            redirect_valid = 1'b0;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stale_byte phase %0d cycle %0d: got valid=%b addr=%h, expected valid 0",
                             k, c, out_valid, out_addr);
                end
                tick;
            end
            checks++;
            if (out_valid !== 1'b1 || out_addr !== target) begin
                failures++;
                $display("[TB] FAIL pending_redirect_head phase %0d: got valid=%b addr=%h, expected 1/%h",
                         k, out_valid, out_addr, target);
            end
            expect_stream(target, 3, gaps);
        end
    endtask

    task automatic test_wrap;
        redirect_valid = 1'b1;
        redirect_addr = 16'hFFFF;
        tick;
        redirect_valid = 1'b0;
        checks++;
        if (read_addr_odd !== 15'h7FFF || read_addr_even !== 15'h0000) begin
            failures++;
            $display("[TB] FAIL wrap_ports: got odd=%h even=%h, expected 7fff/0000", read_addr_odd, read_addr_even);
        end
        expect_stream(16'hFFFF, 4, gaps);
        checks++;
        if (gaps !== 0) begin
            failures++;
            $display("[TB] FAIL throughput_wrap: got %0d bubble cycles, expected 0", gaps);
        end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        tick;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 16'h4000 || out_data !== 8'h00 || read_addr_even !== 15'h2000) begin
            failures++;
            $display("[TB] FAIL mid_reset: got valid=%b addr=%h data=%h even=%h, expected 0/4000/00/2000",
                     out_valid, out_addr, out_data, read_addr_even);
        end
        reset = 1'b0;
        tick;
        tick;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_reset_restart: got valid=%b, expected 1", out_valid);
        end
        expect_stream(16'h4000, 4, gaps);
    endtask

    task automatic test_fetch_disable;
        fetch_en = 1'b0;
        out_ready = 1'b1;
        do_reset;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0 || read_addr_even !== 15'h2000 || read_addr_odd !== 15'h2000) begin
                failures++;
                $display("[TB] FAIL disabled_idle cycle %0d: got valid=%b even=%h odd=%h, expected 0/2000/2000",
                         i, out_valid, read_addr_even, read_addr_odd);
            end
        end
        fetch_en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 16'h4000 || read_addr_even !== 15'h2002) begin
            failures++;
            $display("[TB] FAIL enable_fill: got valid=%b addr=%h even=%h, expected 1/4000/2002",
                     out_valid, out_addr, read_addr_even);
        end
        fetch_en = 1'b0;
        out_ready = 1'b1;
        expect_stream(16'h4000, 4, gaps);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || read_addr_even !== 15'h2002 || read_addr_odd !== 15'h2002) begin
                failures++;
                $display("[TB] FAIL drained cycle %0d: got valid=%b even=%h odd=%h, expected 0/2002/2002",
                         i, out_valid, read_addr_even, read_addr_odd);
            end
            tick;
        end
        fetch_en = 1'b1;
        expect_stream(16'h4004, 4, gaps);
    endtask

    initial begin
        test_reset;
        test_backpressure;
        test_redirect_odd;
        test_redirect_pending;
        test_wrap;
        test_reset_mid;
        test_fetch_disable;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rom_fetch.md
# rom_fetch

Byte-stream instruction fetch front-end for the F8 core, sitting on the initiator side of the dual even/odd ROM read port. It issues a pair of consecutive byte addresses per fetch, one on each port, and absorbs the ROM's one-cycle registered read latency. Returned bytes go into a small prefetch buffer and are presented to the decoder as an address-tagged byte stream with valid/ready handshake. Supports PC redirect (branch/jump) with flush of buffered and in-flight bytes.

## Interface
- `RESET_PC`, 16'h4000, byte address fetched first after reset.
- `BUF_BYTES`, 4, prefetch buffer depth in bytes; power of two, ≥4.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_en` in 1: permits new fetches; buffer drains regardless.
- `redirect_valid` in 1: load new PC, flush.
- `redirect_addr` in 16: new byte PC.
- `read_addr_even` out 15: word address to ROM even port (byte addr {a,0}).
- `read_addr_odd` out 15: word address to ROM odd port (byte addr {a,1}).
- `read_data_even` in 8: even-port data, valid the cycle after address.
- `read_data_odd` in 8: odd-port data, same timing.
- `out_valid` out 1: head byte available.
- `out_data` out 8: head byte.
- `out_addr` out 16: byte address of head byte.
- `out_ready` in 1: consumer accepts head byte.

## Operation
- State: `fetch_ptr` (16b), `pending` (1b), `pend_lo_odd` (1b), buffer with `count`, `head_addr`; FSM {IDLE, RUN}.
- Port addressing from `fetch_ptr` = p: if p even, both ports = p[15:1]; if p odd, odd port = p[15:1], even port = (p+1)[15:1]. Ports are driven combinationally from registers at all times.
- Issue in a cycle iff RUN ∧ `fetch_en` ∧ ¬`redirect_valid` ∧ `count + 2·pending + 2 ≤ BUF_BYTES` (pop this cycle ignored). On issue: `fetch_ptr` += 2 (mod 2^16), `pending`←1, `pend_lo_odd`←p[0]; otherwise `pending`←0.
- Response: if `pending` is set, push two bytes in address order: low byte = `pend_lo_odd` ? `read_data_odd` : `read_data_even`; high byte is the other port.
- Pop on `out_valid ∧ out_ready`: `head_addr` += 1 (mod 2^16). Simultaneous push-2 and pop-1 gives net `count` +1.
- FSM: reset → RUN. RUN → IDLE when `fetch_en`=0. IDLE → RUN when `fetch_en`=1. Redirect does not change state.
- Redirect (priority over push, below reset): a pop in the same cycle is honoured; then `count`←0, `pending`←0 (in-flight response discarded), `fetch_ptr`←`head_addr`←`redirect_addr`.
- Address wrap 0xFFFF→0x0000 is seamless: odd port 0x7FFF, even port 0x0000.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=RESET_PC, `fetch_ptr`=RESET_PC, `pending`=0, `count`=0, state RUN.
- Cycle 0 = first cycle with reset low (or first after redirect): issue. Cycle 1: push. Cycle 2: `out_valid`=1. Redirect/reset-to-first-byte latency is 3 cycles.
- Sustained throughput is 1 byte/cycle with `out_ready` held high and `BUF_BYTES`≥4.
- Reset asserted mid-run: next cycle all state is at reset values; in-flight data is dropped.
- `out_data`/`out_addr` hold stable while `out_valid` ∧ ¬`out_ready`.

## Configuration
- `ROM_FETCH_PERF_EN` defined: adds port `stall_count` out 16, which counts cycles with `out_valid`=0 ∧ RUN, saturates at 0xFFFF, and clears on reset or redirect.
- Not defined: port and counter absent; behaviour otherwise identical.

## Structure
- Package `rom_fetch_pkg`: `fetch_state_t` enum {IDLE, RUN}, `BYTE_W`=8, `ADDR_W`=16.
- Sub-module `fetch_byte_fifo`: circular buffer, 2-byte push, 1-byte pop, flush, exposes `count`. Top level holds FSM, pointer, pending logic and port muxing.

## Test plan
- Reset release, RESET_PC=0x4000, ROM[0x4000..]=0x10,0x11,0x12…, `out_ready`=1 → `out_valid` rises in cycle 2; bytes 0x10,0x11,0x12… on consecutive cycles with `out_addr` 0x4000,0x4001….
- Redirect to 0x4003 → `read_addr_odd`=0x2001, `read_addr_even`=0x2002; first byte out is ROM[0x4003] at `out_addr`=0x4003, three cycles later.
- `out_ready`=0 for 10 cycles after start → `count`=4 and `fetch_ptr` stops at 0x4004; on release, stream resumes with no lost or duplicated byte.
- Redirect in the cycle a response is pending → stale bytes never appear; the next byte out carries `redirect_addr`.
- Redirect to 0xFFFF → bytes ROM[0xFFFF] then ROM[0x0000], with `out_addr` 0xFFFF then 0x0000.
- `reset` pulsed mid-stream, and `fetch_en`=0 → `out_valid`=0 the next cycle and restart at 0x4000; with `fetch_en`=0, no pointer advance and the buffer drains to empty.
